// File: rtl/pipelined_arm_pkg.sv
// Shared definitions for the 5-stage ARM-subset pipeline: ALU codes, decode
// field constants, the D->E pipeline register layout and the built-in program.
package pipelined_arm_pkg;

   typedef enum logic [4:0] {
      ALU_ADD = 5'b00000,
      ALU_SUB = 5'b00001,
      ALU_AND = 5'b00010,
      ALU_ORR = 5'b00011,
      ALU_MOV = 5'b00100,
      ALU_MUL = 5'b00101
   } alu_ctl_t;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   localparam logic [1:0] OP_DP   = 2'b00;
   localparam logic [1:0] OP_MEM  = 2'b01;
   localparam logic [2:0] OP_BR   = 3'b101;
   localparam logic [3:0] MUL_TAG = 4'b1001;

   localparam logic [31:0] NOP_WORD = 32'hE1A00000;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
      logic        alu_src;
      alu_ctl_t    alu_ctl;
      logic [3:0]  ra1;
      logic [3:0]  ra2;
      logic [3:0]  wa;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
   } de_t;

   function automatic logic [31:0] rom_word(input logic [5:0] idx);
      case (idx)
         6'd0:    return 32'hE3A00009;
         6'd1:    return 32'hE3A01006;
         6'd2:    return 32'hE0811000;
         6'd3:    return 32'hE2412007;
         6'd4:    return 32'hE3A04002;
         6'd5:    return 32'hE0030491;
         6'd6:    return 32'hE2444001;
         6'd7:    return 32'hE5802003;
         6'd8:    return 32'hE5905003;
         6'd9:    return 32'hE205500F;
         6'd10:   return 32'hEAFFFFFE;
         default: return NOP_WORD;
      endcase
   endfunction

endpackage

// File: rtl/regfile_15x32.sv
// R0..R14 with two combinational read ports, one write port and a same-cycle
// write bypass; R15 reads return the PC+8 value supplied by the core.
module regfile_15x32 (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  ra1,
   input  logic [3:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [3:0]  wa,
   input  logic [31:0] wd,
   input  logic [31:0] r15
);

   logic [31:0] regs [0:14];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 15; i++) regs[i] <= '0;
      end else if (we && wa != 4'd15) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 4'd15) ? r15 : (we && wa == ra1) ? wd : regs[ra1];
   assign rd2 = (ra2 == 4'd15) ? r15 : (we && wa == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/pipelined_arm_top.sv
// 5-stage F/D/E/M/W ARM-subset core with built-in ROM and data RAM; forwarding
// from M/W, one-cycle load-use stall, branches resolved in E with F/D+D/E flush.
module pipelined_arm_top
   import pipelined_arm_pkg::*;
#(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64
) (
   input logic clk,
   input logic reset
);

   localparam int DA = $clog2(DMEM_WORDS);

   logic [31:0] pc_f, instr_f;
   logic [31:0] pc_d, instr_d;
   logic        vld_d;
   logic [3:0]  ra1_d, ra2_d, wa_d;
   logic [31:0] rd1_d, rd2_d;
   logic        is_mul, is_str, uses_a, uses_b;
   de_t         dec_d, de_e;
   logic [31:0] src_a, fwd_b, src_b, alu_result_e, target_e;
   logic        reg_write_m, mem_write_m, mem_to_reg_m;
   logic [31:0] alu_result_m, write_data_m, read_data_m;
   logic [3:0]  wa_m;
   logic        reg_write_w, mem_to_reg_w;
   logic [31:0] alu_result_w, read_data_w, result_w;
   logic [3:0]  wa_w;
   logic        lw_stall, flush;
   logic [31:0] dmem [0:DMEM_WORDS-1];

   // ---------------- fetch
   assign instr_f = (32'(pc_f[7:2]) < IMEM_WORDS) ? rom_word(pc_f[7:2]) : NOP_WORD;

   always_ff @(posedge clk) begin
      if (reset)          pc_f <= '0;
      else if (flush)     pc_f <= target_e;
      else if (!lw_stall) pc_f <= pc_f + 32'd4;
   end

   // vld_d matters: the no-op word itself decodes as MOV R0,R0
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         vld_d   <= 1'b0;
         instr_d <= NOP_WORD;
         pc_d    <= '0;
      end else if (!lw_stall) begin
         vld_d   <= 1'b1;
         instr_d <= instr_f;
         pc_d    <= pc_f;
      end
   end

   // ---------------- decode
   assign is_mul = (instr_d[27:22] == 6'b0) && (instr_d[7:4] == MUL_TAG);
   assign is_str = (instr_d[27:26] == OP_MEM) && !instr_d[20];
   assign ra1_d  = is_mul ? instr_d[3:0] : instr_d[19:16];
   assign ra2_d  = is_mul ? instr_d[11:8] : is_str ? instr_d[15:12] : instr_d[3:0];
   assign wa_d   = is_mul ? instr_d[19:16] : instr_d[15:12];

   regfile_15x32 rf (
      .clk   (clk),
      .reset (reset),
      .ra1   (ra1_d),
      .ra2   (ra2_d),
      .rd1   (rd1_d),
      .rd2   (rd2_d),
      .we    (reg_write_w),
      .wa    (wa_w),
      .wd    (result_w),
      .r15   (pc_d + 32'd8)
   );

   always_comb begin
      dec_d     = '0;
      uses_a    = 1'b0;
      uses_b    = 1'b0;
      dec_d.ra1 = ra1_d;
      dec_d.ra2 = ra2_d;
      dec_d.wa  = wa_d;
      dec_d.rd1 = rd1_d;
      dec_d.rd2 = rd2_d;
      dec_d.pc  = pc_d;
      if (vld_d) begin
         if (is_mul) begin
            dec_d.reg_write = 1'b1;
            dec_d.alu_ctl   = ALU_MUL;
            uses_a          = 1'b1;
            uses_b          = 1'b1;
         end else if (instr_d[27:26] == OP_DP) begin
            dec_d.reg_write = 1'b1;
            dec_d.alu_src   = instr_d[25];
            dec_d.imm       = {24'b0, instr_d[7:0]};
            uses_a          = 1'b1;
            uses_b          = !instr_d[25];
            case (instr_d[24:21])
               CMD_AND: dec_d.alu_ctl = ALU_AND;
               CMD_SUB: dec_d.alu_ctl = ALU_SUB;
               CMD_ADD: dec_d.alu_ctl = ALU_ADD;
               CMD_ORR: dec_d.alu_ctl = ALU_ORR;
               CMD_MOV: begin
                  dec_d.alu_ctl = ALU_MOV;
                  uses_a        = 1'b0;
               end
               default: dec_d.reg_write = 1'b0;
            endcase
         end else if (instr_d[27:26] == OP_MEM) begin
            dec_d.alu_src = 1'b1;
            dec_d.imm     = {20'b0, instr_d[11:0]};
            dec_d.alu_ctl = instr_d[23] ? ALU_ADD : ALU_SUB;
            uses_a        = 1'b1;
            if (instr_d[20]) begin
               dec_d.reg_write  = 1'b1;
               dec_d.mem_to_reg = 1'b1;
            end else begin
               dec_d.mem_write = 1'b1;
               uses_b          = 1'b1;
            end
         end else if (instr_d[27:25] == OP_BR) begin
            dec_d.branch = 1'b1;
            dec_d.imm    = {{6{instr_d[23]}}, instr_d[23:0], 2'b00};
         end
      end
   end

   // ---------------- hazards
   assign lw_stall = de_e.mem_to_reg &&
                     ((uses_a && ra1_d == de_e.wa) || (uses_b && ra2_d == de_e.wa));
   assign flush    = de_e.branch;

   always_ff @(posedge clk) begin
      if (reset || flush || lw_stall) de_e <= '0;
      else                            de_e <= dec_d;
   end

   // ---------------- execute
   always_comb begin
      src_a = de_e.rd1;
      if (de_e.ra1 != 4'd15) begin
         if (reg_write_m && wa_m == de_e.ra1)      src_a = alu_result_m;
         else if (reg_write_w && wa_w == de_e.ra1) src_a = result_w;
      end
   end

   always_comb begin
      fwd_b = de_e.rd2;
      if (de_e.ra2 != 4'd15) begin
         if (reg_write_m && wa_m == de_e.ra2)      fwd_b = alu_result_m;
         else if (reg_write_w && wa_w == de_e.ra2) fwd_b = result_w;
      end
   end

   assign src_b = de_e.alu_src ? de_e.imm : fwd_b;

   always_comb begin
      case (de_e.alu_ctl)
         ALU_ADD: alu_result_e = src_a + src_b;
         ALU_SUB: alu_result_e = src_a - src_b;
         ALU_AND: alu_result_e = src_a & src_b;
         ALU_ORR: alu_result_e = src_a | src_b;
         ALU_MOV: alu_result_e = src_b;
         ALU_MUL: alu_result_e = src_a * src_b;
         default: alu_result_e = src_a + src_b;
      endcase
   end

   assign target_e = de_e.pc + 32'd8 + de_e.imm;

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         mem_to_reg_m <= 1'b0;
         alu_result_m <= '0;
         write_data_m <= '0;
         wa_m         <= '0;
      end else begin
         reg_write_m  <= de_e.reg_write;
         mem_write_m  <= de_e.mem_write;
         mem_to_reg_m <= de_e.mem_to_reg;
         alu_result_m <= alu_result_e;
         write_data_m <= fwd_b;
         wa_m         <= de_e.wa;
      end
   end

   // ---------------- memory (RAM contents survive reset)
   assign read_data_m = dmem[alu_result_m[DA+1:2]];

   always_ff @(posedge clk) begin
      if (mem_write_m) dmem[alu_result_m[DA+1:2]] <= write_data_m;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_w  <= 1'b0;
         mem_to_reg_w <= 1'b0;
         alu_result_w <= '0;
         read_data_w  <= '0;
         wa_w         <= '0;
      end else begin
         reg_write_w  <= reg_write_m;
         mem_to_reg_w <= mem_to_reg_m;
         alu_result_w <= alu_result_m;
         read_data_w  <= read_data_m;
         wa_w         <= wa_m;
      end
   end

   // ---------------- writeback
   assign result_w = mem_to_reg_w ? read_data_w : alu_result_w;

   logic unused_bits;
   assign unused_bits = ^{instr_d[31:28], pc_f[31:8], pc_f[1:0],
                          alu_result_m[31:DA+2], alu_result_m[1:0]};

endmodule

// File: tb/tb_pipelined_arm_top.sv
// Scoreboarded bench: an ISA-level model predicts every register/RAM write and
// its cycle; a monitor matches them against W/M-stage activity.
module tb_pipelined_arm_top;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pipelined_arm_top #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
      .clk   (clk),
      .reset (reset)
   );

   typedef struct {
      bit          is_mem;
      int          idx;
      logic [31:0] val;
      int          cyc;
   } ev_t;

   ev_t         exp_q [$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] m_regs [0:15];
   logic [31:0] m_mem  [int];
   logic [31:0] m_pc;
   logic [31:0] prog [0:10] = '{32'hE3A00009, 32'hE3A01006, 32'hE0811000, 32'hE2412007,
                                32'hE3A04002, 32'hE0030491, 32'hE2444001, 32'hE5802003,
                                32'hE5905003, 32'hE205500F, 32'hEAFFFFFE};

   function automatic logic [31:0] rv(input logic [3:0] x);
      return (x == 4'd15) ? m_pc + 32'd8 : m_regs[x];
   endfunction

   // Architectural interpreter; the issue slot advances one per instruction,
   // +1 for a load feeding the next instruction, +2 after a taken branch.
   task automatic run_model();
      int  slot, ld_rd;
      bit  done;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_pc = '0; slot = 0; ld_rd = -1; done = 0;
      for (int step = 0; step < 64 && !done; step++) begin
         logic [31:0] w, a, b, res, addr, tgt;
         int  sa, sb, rd;
         bit  wr, is_ld, is_st, br;
         w  = (m_pc[31:2] < 11) ? prog[m_pc[31:2]] : 32'hE1A00000;
         sa = -1; sb = -1; wr = 0; is_ld = 0; is_st = 0; br = 0;
         rd = int'(w[15:12]); res = '0; addr = '0; tgt = '0;
         if (w[27:22] == 6'd0 && w[7:4] == 4'h9) begin
            sa = int'(w[3:0]); sb = int'(w[11:8]); rd = int'(w[19:16]);
            wr = 1; res = rv(w[3:0]) * rv(w[11:8]);
         end else if (w[27:26] == 2'b00) begin
            a = rv(w[19:16]);
            b = w[25] ? {24'b0, w[7:0]} : rv(w[3:0]);
            if (!w[25]) sb = int'(w[3:0]);
            sa = int'(w[19:16]);
            wr = 1;
            case (w[24:21])
               4'b0000: res = a & b;
               4'b0010: res = a - b;
               4'b0100: res = a + b;
               4'b1100: res = a | b;
               4'b1101: begin res = b; sa = -1; end
               default: wr = 0;
            endcase
         end else if (w[27:26] == 2'b01) begin
            sa   = int'(w[19:16]);
            addr = w[23] ? rv(w[19:16]) + {20'b0, w[11:0]} : rv(w[19:16]) - {20'b0, w[11:0]};
            if (w[20]) begin
               wr = 1; is_ld = 1;
               res = m_mem.exists(int'(addr[7:2])) ? m_mem[int'(addr[7:2])] : '0;
            end else begin
               is_st = 1; sb = rd;
            end
         end else if (w[27:25] == 3'b101) begin
            br  = 1;
            tgt = m_pc + 32'd8 + {{6{w[23]}}, w[23:0], 2'b00};
         end
         if (ld_rd >= 0 && (sa == ld_rd || sb == ld_rd)) slot++;
         if (is_st) begin
            m_mem[int'(addr[7:2])] = rv(w[15:12]);
            exp_q.push_back('{1'b1, int'(addr[7:2]), rv(w[15:12]), slot + 3});
         end
         if (wr) begin
            exp_q.push_back('{1'b0, rd, res, slot + 4});
            if (rd != 15) m_regs[rd] = res;
         end
         ld_rd = is_ld ? rd : -1;
         if (br) begin
            if (tgt == m_pc) done = 1;
            else begin m_pc = tgt; slot += 3; end
         end else begin
            m_pc = m_pc + 32'd4; slot++;
         end
      end
   endtask

   task automatic check_ev(input bit k, input int idx, input logic [31:0] v);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_write: got mem=%0b idx=%0d val=%0d cyc=%0d, required none",
                  k, idx, v, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.is_mem != k || e.idx != idx || e.val != v || e.cyc != cyc) begin
            errors++;
            $display("FAIL write_event: got mem=%0b idx=%0d val=%0d cyc=%0d, required mem=%0b idx=%0d val=%0d cyc=%0d",
                     k, idx, v, cyc, e.is_mem, e.idx, e.val, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (reset) cyc = 0;
      else begin
         if (dut.reg_write_w) check_ev(1'b0, int'(dut.wa_w), dut.result_w);
         if (dut.mem_write_m) check_ev(1'b1, int'(dut.alu_result_m[7:2]), dut.write_data_m);
         cyc++;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d (0x%08h), required %0d (0x%08h)", name, got, got, want, want);
      end
   endtask

   task automatic check_reset_state();
      check("reset_pc", dut.pc_f, 32'd0);
      check("reset_bubble_e", {29'b0, dut.de_e.reg_write, dut.de_e.mem_write, dut.de_e.branch}, 32'd0);
      check("reset_bubble_mw", {30'b0, dut.reg_write_m | dut.mem_write_m, dut.reg_write_w}, 32'd0);
      for (int i = 0; i < 15; i++) check($sformatf("reset_r%0d", i), dut.rf.regs[i], 32'd0);
   endtask

   task automatic check_final();
      check("queue_drained", exp_q.size(), 32'd0);
      for (int i = 0; i < 15; i++) check($sformatf("final_r%0d", i), dut.rf.regs[i], m_regs[i]);
      check("final_mem3", dut.dmem[3], m_mem[3]);
   endtask

   // Reset the running program after `pre` cycles, hold for `hold` cycles, restart.
   task automatic mid_reset(input int pre, input int hold);
      repeat (pre) @(posedge clk);
      #1 reset = 1'b1;
      exp_q.delete();
      repeat (hold) @(posedge clk);
      #1 check_reset_state();
      reset = 1'b0;
      run_model();
   endtask

   task automatic check_loop();
      int hits, stray;
      logic [31:0] snap [0:14];
      hits = 0; stray = 0;
      for (int i = 0; i < 15; i++) snap[i] = dut.rf.regs[i];
      for (int n = 0; n < 99; n++) begin
         @(posedge clk); #1;
         if (dut.pc_f == 32'h28) hits++;
         else if (dut.pc_f != 32'h2C && dut.pc_f != 32'h30) stray++;
      end
      check("loop_pc_hits", hits, 32'd33);
      check("loop_pc_stray", stray, 32'd0);
      for (int i = 0; i < 15; i++) check($sformatf("loop_r%0d", i), dut.rf.regs[i], snap[i]);
   endtask

   initial begin
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1 check_reset_state();
      reset = 1'b0;
      run_model();
      mid_reset(6, 2);
      repeat (200) @(posedge clk);
      #1 check_final();
      check_loop();
      for (int ep = 0; ep < 5; ep++) begin
         mid_reset($urandom_range(1, 25), $urandom_range(1, 3));
         repeat (120) @(posedge clk);
         #1 check_final();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
